// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop processes one
// operand bit pair per clock, LSB first, with a start/busy/done handshake.

// Single-bit full adder cell shared by every bit position of the serial add.
module FullAdderCell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_sumSh;
  logic             r_cFf;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_nextSumSh;

  FullAdderCell u_fa (
    .i_a  (r_aSh[0]),
    .i_b  (r_bSh[0]),
    .i_c  (r_cFf),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_lastBit   = (r_cnt == LAST_BIT);
  assign w_nextSumSh = {w_s, r_sumSh[WIDTH-1:1]};

  // Sequence IDLE -> RUN for WIDTH bit cycles -> DONE for one cycle -> IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) r_state <= ST_RUN;
        ST_RUN:  if (w_lastBit) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture operands on an accepted start, then shift one bit pair per RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_sumSh <= '0;
      r_cFf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_aSh   <= i_a;
        r_bSh   <= i_b;
        r_sumSh <= '0;
        r_cFf   <= i_cin;
        r_cnt   <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_aSh   <= r_aSh >> 1;
      r_bSh   <= r_bSh >> 1;
      r_sumSh <= w_nextSumSh;
      r_cFf   <= w_co;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Publish the result only on the final bit so the previous sum stays visible.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if ((r_state == ST_RUN) && w_lastBit) begin
      r_sum  <= w_nextSumSh;
      r_cout <= w_co;
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake, hold,
// ignore-start and reset behaviour, and a 4-bit instance swept exhaustively.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int compareCount  = 0;
  int mismatchCount = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start8),
    .i_a     (a8),
    .i_b     (b8),
    .i_cin   (cin8),
    .o_busy  (busy8),
    .o_done  (done8),
    .o_sum   (sum8),
    .o_cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start4),
    .i_a     (a4),
    .i_b     (b4),
    .i_cin   (cin4),
    .o_busy  (busy4),
    .o_done  (done4),
    .o_sum   (sum4),
    .o_cout  (cout4)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Run one 8-bit add and check latency, busy, held result and the final sum.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [7:0] expSum, input logic expCout,
                               input logic [7:0] prevSum, input logic prevCout);
    int n;
    a8 = a;
    b8 = b;
    cin8 = cin;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~a;
    b8 = ~b;
    cin8 = ~cin;
    checkOutput("busyAfterStart", {31'd0, busy8}, 32'd1);
    n = 0;
    do begin
      tick();
      n++;
      if (!done8) begin
        checkOutput("busyDuringRun", {31'd0, busy8}, 32'd1);
        checkOutput("sumHeldDuringRun", {23'd0, cout8, sum8}, {23'd0, prevCout, prevSum});
      end
    end while (!done8 && n < 20);
    checkOutput("latency", n, 32'd8);
    checkOutput("busyInDone", {31'd0, busy8}, 32'd0);
    checkOutput("result", {23'd0, cout8, sum8}, {23'd0, expCout, expSum});
    tick();
    checkOutput("doneOnePulse", {31'd0, done8}, 32'd0);
    checkOutput("busyAfterDone", {31'd0, busy8}, 32'd0);
    checkOutput("resultHeldIdle", {23'd0, cout8, sum8}, {23'd0, expCout, expSum});
  endtask

  initial begin
    int doneCnt;
    int n;
    logic [4:0] exp4;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("resetBusy", {31'd0, busy8}, 32'd0);
    checkOutput("resetDone", {31'd0, done8}, 32'd0);
    checkOutput("resetResult", {23'd0, cout8, sum8}, 32'd0);

    applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    applyStimulus(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 8'h00, 1'b1);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h7E, 1'b0);

    // Start re-pulsed mid-run (edge E0+3) and in the DONE cycle (edge E0+9).
    a8 = 8'h12;
    b8 = 8'h34;
    cin8 = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    doneCnt = 0;
    for (int k = 1; k <= 12; k++) begin
      start8 = (k == 3 || k == 9);
      a8 = start8 ? 8'h11 : 8'h00;
      b8 = start8 ? 8'h22 : 8'h00;
      cin8 = 1'b0;
      tick();
      if (done8) doneCnt++;
    end
    start8 = 1'b0;
    checkOutput("ignoredStartDonePulses", doneCnt, 32'd1);
    checkOutput("ignoredStartResult", {23'd0, cout8, sum8}, 32'h047);
    checkOutput("ignoredStartIdle", {31'd0, busy8}, 32'd0);

    // Reset asserted at E0+4 aborts the add without a done pulse.
    a8 = 8'hFF;
    b8 = 8'hFF;
    cin8 = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abortBusy", {31'd0, busy8}, 32'd0);
    checkOutput("abortDone", {31'd0, done8}, 32'd0);
    checkOutput("abortResult", {23'd0, cout8, sum8}, 32'd0);
    doneCnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 || busy8) doneCnt++;
    end
    checkOutput("abortNoActivity", doneCnt, 32'd0);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    // Reset and start on the same edge: reset wins.
    a8 = 8'h01;
    b8 = 8'h01;
    start8 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start8 = 1'b0;
    checkOutput("resetBeatsStart", {31'd0, busy8}, 32'd0);
    checkOutput("resetBeatsStartResult", {23'd0, cout8, sum8}, 32'd0);

    // 4-bit sweep with start held high: one result every 6 cycles.
    a4 = 4'h0;
    b4 = 4'h0;
    cin4 = 1'b0;
    start4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done4 && n < 12);
      exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
      checkOutput("sweepDone", {31'd0, done4}, 32'd1);
      checkOutput("sweepResult", {27'd0, cout4, sum4}, {27'd0, exp4});
      if (i > 0) checkOutput("sweepPeriod", n, 32'd6);
      a4 = 4'(i + 1);
      b4 = 4'((i + 1) >> 4);
      cin4 = 1'((i + 1) >> 8);
    end
    start4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
